// File: rtl/sum_frame_accumulator.sv
// Frame accumulator for the 32-bit sum stream: collects FRAME_LEN words (or fewer on flush)
// and holds a saturating total, unsigned maximum and word count until the consumer accepts.
module sum_frame_accumulator #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned ACC_W     = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_sum,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [31:0]      out_max,
  output logic [7:0]       out_count,
  output logic             out_sat
);

  localparam logic [7:0]       LastCount = 8'(FRAME_LEN);
  localparam logic [ACC_W-1:0] TotalMax  = '1;

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e           state_q, state_d;
  logic             ready_q;
  logic [7:0]       count_q, count_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic [31:0]      max_q, max_d;
  logic             sat_q, sat_d;

  logic [ACC_W-1:0] res_total_q;
  logic [31:0]      res_max_q;
  logic [7:0]       res_count_q;
  logic             res_sat_q;

  logic             accept;
  logic             load_res;
  logic [ACC_W:0]   in_ext;
  logic [ACC_W:0]   sum_ext;

  assign accept = in_valid & ready_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    total_d = total_q;
    max_d   = max_q;
    sat_d   = sat_q;
    in_ext  = '0;
    in_ext[31:0] = in_sum;
    // One extra bit catches the carry that signals saturation.
    sum_ext = {1'b0, total_q} + in_ext;

    case (state_q)
      StIdle: begin
        if (accept) begin
          count_d = 8'd1;
          total_d = in_ext[ACC_W-1:0];
          max_d   = in_sum;
          sat_d   = 1'b0;
          state_d = (FRAME_LEN == 1) ? StHold : StAcc;
        end
      end
      StAcc: begin
        if (accept) begin
          count_d = count_q + 8'd1;
          if (sum_ext[ACC_W]) begin
            total_d = TotalMax;
            sat_d   = 1'b1;
          end else begin
            total_d = sum_ext[ACC_W-1:0];
          end
          max_d = (in_sum > max_q) ? in_sum : max_q;
          if ((count_d == LastCount) || flush) state_d = StHold;
        end else if (flush) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          count_d = '0;
          total_d = '0;
          max_d   = '0;
          sat_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Results are captured on HOLD entry so they survive the accumulator clear.
  assign load_res = (state_d == StHold) && (state_q != StHold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      count_q     <= '0;
      total_q     <= '0;
      max_q       <= '0;
      sat_q       <= 1'b0;
      res_total_q <= '0;
      res_max_q   <= '0;
      res_count_q <= '0;
      res_sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != StHold);
      count_q <= count_d;
      total_q <= total_d;
      max_q   <= max_d;
      sat_q   <= sat_d;
      if (load_res) begin
        res_total_q <= total_d;
        res_max_q   <= max_d;
        res_count_q <= count_d;
        res_sat_q   <= sat_d;
      end
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q == StHold);
  assign out_total = res_total_q;
  assign out_max   = res_max_q;
  assign out_count = res_count_q;
  assign out_sat   = res_sat_q;

endmodule

// File: tb/tb_sum_frame_accumulator.sv
// Directed bench: three accumulator instances (FRAME_LEN 4/40-bit, 3/33-bit, 1/40-bit) driven
// one at a time, checked with immediate assertions against hand-computed frame results.
module tb_sum_frame_accumulator;

  logic        clk;
  logic        rst_n;
  logic [2:0]  v, f, o;
  logic [31:0] s [3];
  logic [2:0]  r, ov, st;
  logic [31:0] mx [3];
  logic [7:0]  cnt [3];
  logic [39:0] tot [3];
  logic [39:0] t0, t2;
  logic [32:0] t1;

  int n_assert = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sum_frame_accumulator #(.FRAME_LEN(4), .ACC_W(40)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_ready(r[0]), .in_sum(s[0]), .flush(f[0]),
    .out_valid(ov[0]), .out_ready(o[0]), .out_total(t0), .out_max(mx[0]), .out_count(cnt[0]),
    .out_sat(st[0])
  );

  sum_frame_accumulator #(.FRAME_LEN(3), .ACC_W(33)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_ready(r[1]), .in_sum(s[1]), .flush(f[1]),
    .out_valid(ov[1]), .out_ready(o[1]), .out_total(t1), .out_max(mx[1]), .out_count(cnt[1]),
    .out_sat(st[1])
  );

  sum_frame_accumulator #(.FRAME_LEN(1), .ACC_W(40)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v[2]), .in_ready(r[2]), .in_sum(s[2]), .flush(f[2]),
    .out_valid(ov[2]), .out_ready(o[2]), .out_total(t2), .out_max(mx[2]), .out_count(cnt[2]),
    .out_sat(st[2])
  );

  assign tot[0] = t0;
  assign tot[1] = {7'd0, t1};
  assign tot[2] = t2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input int u, input string tag, input logic [39:0] t,
                         input logic [31:0] m, input logic [7:0] c, input logic sa);
    chk({tag, "_valid"}, 64'(ov[u]), 64'd1);
    chk({tag, "_ready"}, 64'(r[u]), 64'd0);
    chk({tag, "_total"}, 64'(tot[u]), 64'(t));
    chk({tag, "_max"}, 64'(mx[u]), 64'(m));
    chk({tag, "_count"}, 64'(cnt[u]), 64'(c));
    chk({tag, "_sat"}, 64'(st[u]), 64'(sa));
  endtask

  task automatic chk_idle(input int u, input string tag);
    chk({tag, "_valid"}, 64'(ov[u]), 64'd0);
    chk({tag, "_ready"}, 64'(r[u]), 64'd1);
  endtask

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic push(input int u, input logic [31:0] d, input logic fl);
    int n;
    n = 0;
    v[u] = 1'b1;
    s[u] = d;
    f[u] = fl;
    while (r[u] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_assert++;
      n_fail++;
      $error("FAIL push_timeout: observed in_ready=%0b expected 1 within 20 cycles", r[u]);
    end
    @(negedge clk);
    v[u] = 1'b0;
    f[u] = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    v = '0;
    f = '0;
    o = '0;
    for (int i = 0; i < 3; i++) s[i] = '0;
    #1;
    chk("rst_valid", 64'(ov), 64'd0);
    chk("rst_ready", 64'(r), 64'd0);
    chk("rst_total", 64'(tot[0]), 64'd0);
    chk("rst_count", 64'(cnt[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic frame with immediate handshake.
    o[0] = 1'b1;
    push(0, 1, 0); push(0, 2, 0); push(0, 3, 0); push(0, 4, 0);
    chk_res(0, "t1", 40'd10, 32'd4, 8'd4, 1'b0);
    @(negedge clk);
    chk_idle(0, "t1_after");
    chk("t1_total_kept", 64'(tot[0]), 64'd10);

    // Backpressure; word 7 waits through HOLD and starts the next frame.
    o[0] = 1'b0;
    push(0, 1, 0); push(0, 2, 0); push(0, 3, 0); push(0, 4, 0);
    v[0] = 1'b1;
    s[0] = 32'd7;
    for (int i = 0; i < 5; i++) begin
      chk_res(0, "t2_hold", 40'd10, 32'd4, 8'd4, 1'b0);
      @(negedge clk);
    end
    o[0] = 1'b1;
    @(negedge clk);
    chk_idle(0, "t2_release");
    @(negedge clk);
    v[0] = 1'b0;
    push(0, 0, 0); push(0, 0, 0); push(0, 0, 0);
    chk_res(0, "t2_next", 40'd7, 32'd7, 8'd4, 1'b0);
    @(negedge clk);

    // Flush alone, flush with an accept, flush in IDLE.
    push(0, 5, 0); push(0, 32'h20, 0);
    f[0] = 1'b1;
    @(negedge clk);
    f[0] = 1'b0;
    chk_res(0, "t3_flush", 40'h25, 32'h20, 8'd2, 1'b0);
    @(negedge clk);
    chk_idle(0, "t3_flush_after");
    push(0, 5, 0); push(0, 32'h20, 0); push(0, 9, 1);
    chk_res(0, "t3_flushacc", 40'h2E, 32'h20, 8'd3, 1'b0);
    @(negedge clk);
    f[0] = 1'b1;
    @(negedge clk);
    f[0] = 1'b0;
    chk_idle(0, "t3_idleflush");
    chk("t3_idleflush_total", 64'(tot[0]), 64'h2E);
    @(negedge clk);
    chk_idle(0, "t3_idleflush2");

    // Asynchronous reset mid-frame.
    push(0, 9, 0); push(0, 9, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", 64'(ov[0]), 64'd0);
    chk("t5_ready", 64'(r[0]), 64'd0);
    chk("t5_total", 64'(tot[0]), 64'd0);
    chk("t5_count", 64'(cnt[0]), 64'd0);
    chk("t5_max", 64'(mx[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 2, 0); push(0, 2, 0); push(0, 2, 0); push(0, 2, 0);
    chk_res(0, "t5_after", 40'd8, 32'd2, 8'd4, 1'b0);
    @(negedge clk);

    // Saturation in a 33-bit accumulator, then the flag clears on the next frame.
    o[1] = 1'b1;
    push(1, 32'hFFFF_FFFF, 0); push(1, 32'hFFFF_FFFF, 0); push(1, 32'hFFFF_FFFF, 0);
    chk_res(1, "t4_sat", 40'h1_FFFF_FFFF, 32'hFFFF_FFFF, 8'd3, 1'b1);
    @(negedge clk);
    chk_idle(1, "t4_after");
    push(1, 1, 0); push(1, 1, 0); push(1, 1, 0);
    chk_res(1, "t4_clear", 40'd3, 32'd1, 8'd3, 1'b0);
    @(negedge clk);

    // FRAME_LEN=1 with in_valid held high.
    o[2] = 1'b1;
    v[2] = 1'b1;
    s[2] = 32'h11;
    n = 0;
    while (r[2] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_ready_wait", 64'(r[2]), 64'd1);
    @(negedge clk);
    chk_res(2, "t6_first", 40'h11, 32'h11, 8'd1, 1'b0);
    s[2] = 32'h22;
    @(negedge clk);
    chk_idle(2, "t6_gap");
    @(negedge clk);
    chk_res(2, "t6_second", 40'h22, 32'h22, 8'd1, 1'b0);
    v[2] = 1'b0;
    @(negedge clk);
    chk_idle(2, "t6_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
